// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter sharing one N-bit channel among M requesters, with a
// bounded hold time and an internal enabler mux that steers the owner's data.

module Multiplexer_with_enabler_MxN #(
  parameter int M     = 4,
  parameter int N     = 8,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]     sel,
  input  logic                 en,
  input  logic [M-1:0][N-1:0]  data_in,
  output logic [N-1:0]         data_out
);

  // Steer the selected lane out; force zero when disabled so idle never leaks data.
  always_comb begin
    data_out = {N{1'b0}};
    if (en) begin
      data_out = data_in[sel];
    end else begin
      data_out = {N{1'b0}};
    end
  end

endmodule

module rr_channel_arbiter #(
  parameter int M          = 4,
  parameter int N          = 8,
  parameter int MAX_HOLD   = 16,
  localparam int SEL_W     = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M-1:0]         req,
  input  logic [M-1:0][N-1:0]  req_data,
  output logic [M-1:0]         grant,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 bus_valid,
  output logic [N-1:0]         bus_data,
  output logic                 timeout
);

  localparam int HC_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r;
  logic [M-1:0]      grant_r;
  logic [SEL_W-1:0]  grant_idx_r;
  logic              valid_r;
  logic              timeout_r;
  logic [SEL_W-1:0]  ptr_r;
  logic [HC_W-1:0]   hold_cnt_r;

  logic [M-1:0]      cand_s;
  logic              found_s;
  logic [SEL_W-1:0]  win_s;
  logic [SEL_W-1:0]  idx_s;
  logic [M-1:0]      win_onehot_s;
  logic [SEL_W-1:0]  nxt_ptr_s;
  logic              owner_req_s;
  logic              hold_last_s;

  // Round-robin search from ptr; the current owner is always excluded, which
  // covers release (its req is low anyway) and preemption alike.
  always_comb begin
    int idx_v;
    idx_v   = 0;
    idx_s   = {SEL_W{1'b0}};
    cand_s  = req & ~grant_r;
    found_s = 1'b0;
    win_s   = {SEL_W{1'b0}};
    for (int k = 0; k < M; k++) begin
      idx_v = int'(ptr_r) + k;
      if (idx_v >= M) begin
        idx_v = idx_v - M;
      end else begin
        idx_v = idx_v;
      end
      idx_s = SEL_W'(idx_v);
      if (!found_s && cand_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        win_s   = win_s;
      end
    end
  end

  // Decode winner to one-hot and derive the pointer that follows it.
  always_comb begin
    win_onehot_s = {M{1'b0}};
    for (int i = 0; i < M; i++) begin
      win_onehot_s[i] = (win_s == SEL_W'(i));
    end
    if (win_s == SEL_W'(M - 1)) begin
      nxt_ptr_s = {SEL_W{1'b0}};
    end else begin
      nxt_ptr_s = win_s + SEL_W'(1);
    end
    owner_req_s = req[grant_idx_r];
    hold_last_s = (hold_cnt_r >= HC_W'(MAX_HOLD - 1));
  end

  // Ownership FSM: grant, hold counting, release and preemption.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_r     <= {M{1'b0}};
      grant_idx_r <= {SEL_W{1'b0}};
      valid_r     <= 1'b0;
      timeout_r   <= 1'b0;
      ptr_r       <= {SEL_W{1'b0}};
      hold_cnt_r  <= {HC_W{1'b0}};
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r     <= BUSY;
            grant_r     <= win_onehot_s;
            grant_idx_r <= win_s;
            valid_r     <= 1'b1;
            ptr_r       <= nxt_ptr_s;
            hold_cnt_r  <= {HC_W{1'b0}};
          end else begin
            state_r     <= IDLE;
          end
        end
        BUSY: begin
          if (!owner_req_s) begin
            if (found_s) begin
              grant_r     <= win_onehot_s;
              grant_idx_r <= win_s;
              ptr_r       <= nxt_ptr_s;
              hold_cnt_r  <= {HC_W{1'b0}};
            end else begin
              state_r     <= IDLE;
              grant_r     <= {M{1'b0}};
              grant_idx_r <= {SEL_W{1'b0}};
              valid_r     <= 1'b0;
              hold_cnt_r  <= {HC_W{1'b0}};
            end
          end else if (!hold_last_s) begin
            hold_cnt_r <= hold_cnt_r + HC_W'(1);
          end else if (found_s) begin
            grant_r     <= win_onehot_s;
            grant_idx_r <= win_s;
            ptr_r       <= nxt_ptr_s;
            hold_cnt_r  <= {HC_W{1'b0}};
            timeout_r   <= 1'b1;
          end else begin
            // Nobody else waiting: the owner simply starts a fresh hold window.
            hold_cnt_r <= {HC_W{1'b0}};
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_r     <= {M{1'b0}};
          grant_idx_r <= {SEL_W{1'b0}};
          valid_r     <= 1'b0;
          hold_cnt_r  <= {HC_W{1'b0}};
        end
      endcase
    end
  end

  Multiplexer_with_enabler_MxN #(.M(M), .N(N), .SEL_W(SEL_W)) u_mux (
    .sel      (grant_idx_r),
    .en       (valid_r),
    .data_in  (req_data),
    .data_out (bus_data)
  );

  assign grant     = grant_r;
  assign grant_idx = grant_idx_r;
  assign bus_valid = valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter: an ownership model checked every cycle
// plus literal expectations for reset, single request, fairness, preemption and hog.

module tb_rr_channel_arbiter;

  localparam int M  = 4;
  localparam int N  = 8;
  localparam int MH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [M-1:0]      req;
  logic [M-1:0][N-1:0] req_data;
  logic [M-1:0]      grant;
  logic [1:0]        grant_idx;
  logic              bus_valid;
  logic [N-1:0]      bus_data;
  logic              timeout;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  rr_channel_arbiter #(.M(M), .N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .grant_idx(grant_idx), .bus_valid(bus_valid),
    .bus_data(bus_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int p, input int excl, input logic [M-1:0] r);
    for (int k = 0; k < M; k++) begin
      int i;
      i = (p + k) % M;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  // Ownership model: who holds the channel, for how many cycles, where the scan starts.
  always @(posedge clk) begin
    int o, p, h, w;
    bit t;
    o = m_owner; p = m_ptr; h = m_held; t = 1'b0;
    if (rst) begin
      o = -1; p = 0; h = 0;
    end else if (o < 0) begin
      w = pick(p, -1, req);
      if (w >= 0) begin o = w; p = (w + 1) % M; h = 1; end
    end else if (!req[o]) begin
      w = pick(p, o, req);
      if (w >= 0) begin o = w; p = (w + 1) % M; h = 1; end
      else o = -1;
    end else if (h < MH) begin
      h = h + 1;
    end else begin
      w = pick(p, o, req);
      if (w >= 0) begin o = w; p = (w + 1) % M; h = 1; t = 1'b1; end
      else h = 1;
    end
    m_owner <= o; m_ptr <= p; m_held <= h; m_to <= t;
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [M-1:0] eg;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_grant", grant, eg);
      chk("model_valid", bus_valid, (m_owner >= 0));
      chk("model_data", bus_data, (m_owner >= 0) ? req_data[m_owner] : 8'h00);
      chk("model_timeout", timeout, m_to);
      if (m_owner >= 0) chk("model_idx", grant_idx, m_owner);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int order [4] = '{1, 2, 3, 0};
    int cur;
    logic [M-1:0] e;

    rst = 1'b1;
    req = 4'b1111;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_data", bus_data, 8'h00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_idx", grant_idx, 2'd0);

    rst = 1'b0; req = 4'b0000;
    cyc(1);
    chk("idle_grant", grant, 4'b0000);

    // Single request
    req = 4'b0100;
    cyc(1);
    chk("single_grant", grant, 4'b0100);
    chk("single_idx", grant_idx, 2'd2);
    chk("single_data", bus_data, 8'hA5);
    req = 4'b0000;
    cyc(1);
    chk("single_rel_grant", grant, 4'b0000);
    chk("single_rel_data", bus_data, 8'h00);

    // Fairness with pointer wrap
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b1111;
    cyc(1);
    chk("fair_first", grant, 4'b0001);
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(2);
      req[cur] = 1'b0;
      cyc(1);
      e = 4'b0001 << order[k];
      chk("fair_grant", grant, e);
      chk("fair_valid", bus_valid, 1'b1);
      chk("fair_timeout", timeout, 1'b0);
      req[cur] = 1'b1;
      cur = order[k];
    end
    req = 4'b0000;
    cyc(1);
    chk("fair_end", grant, 4'b0000);

    // Preemption after MAX_HOLD cycles
    req = 4'b0010;
    cyc(1);
    chk("pre_own1", grant, 4'b0010);
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("pre_hold", grant, 4'b0010);
      chk("pre_hold_to", timeout, 1'b0);
    end
    cyc(1);
    chk("pre_grant", grant, 4'b1000);
    chk("pre_timeout", timeout, 1'b1);
    chk("pre_idx", grant_idx, 2'd3);
    chk("pre_data", bus_data, 8'h44);
    cyc(1);
    chk("pre_to_pulse", timeout, 1'b0);
    chk("pre_after", grant, 4'b1000);
    req = 4'b0000;
    cyc(1);

    // Lone hog keeps the channel, never times out
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk("hog_grant", grant, 4'b0001);
      chk("hog_timeout", timeout, 1'b0);
    end
    req = 4'b0000;
    cyc(1);

    // Mid-operation reset
    req = 4'b0100;
    cyc(1);
    chk("mid_own2", grant, 4'b0100);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_grant", grant, 4'b0000);
    chk("mid_rst_valid", bus_valid, 1'b0);
    chk("mid_rst_to", timeout, 1'b0);
    rst = 1'b0; req = 4'b0110;
    cyc(1);
    chk("mid_first", grant, 4'b0010);
    chk("mid_idx", grant_idx, 2'd1);
    chk("mid_data", bus_data, 8'h22);
    req = 4'b0000;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
